acc_datapath_gen: RTL and testbench
===================================

ACC_DATAPATH_GEN -- requirements
Module: acc_datapath_gen

Interface
REQ-001 The block SHALL have the following parameters:
- DW, 16: data, ACC, MDR and IR width; even and at least 8.
- AW, 8: address, PC and MAR width; AW < DW.
- OPW, DW-AW: opcode width (derived).
- MN, DW/2: multiplier operand width (derived).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- loadPC, in, 1: PC write enable.
- muxPC, in, 1: PC source; 1 = IR operand address, 0 = PC+1.
- loadMAR, in, 1: MAR write enable.
- muxMAR, in, 1: MAR source; 1 = IR operand address, 0 = PC.
- loadIR, in, 1: IR <= MDR.
- loadMDR, in, 1: MDR <= MemQ.
- loadACC, in, 1: ACC write enable.
- muxACC, in, 2: ACC source; 00 = ALU, 01 = MDR, 10 = product register, 11 = zero.
- opALU, in, 2: ALU operation; 00 = ADD, 01 = SUB, 10 = AND, 11 = OR.
- mult_start, in, 1: multiply request.
- mult_busy, out, 1: multiplier running.
- mult_done, out, 1: one-cycle completion pulse.
- zflag, out, 1: ACC equals zero.
- cflag, out, 1: carry/borrow from the last ADD/SUB loaded into ACC.
- opcode, out, OPW: IR[OPW-1:0].
- MemAddr, out, AW: MAR.
- MemD, out, DW: ACC.
- MemQ, in, DW: memory read data.

Function
REQ-003 The operand address SHALL be IR[DW-1:OPW]; opcode, MemAddr and MemD SHALL be driven directly from the registers with no extra delay.
REQ-004 Every register SHALL hold its value when its load enable is 0.
REQ-005 PC+1 SHALL wrap modulo 2^AW (all-ones -> 0).
REQ-006 The ALU SHALL operate on A = ACC and B = MDR:
- ADD: result = A+B mod 2^DW; carry = bit DW of the sum.
- SUB: result = A-B mod 2^DW; carry = 1 iff B > A (unsigned borrow).
- AND and OR: bitwise.
REQ-007 cflag SHALL update only on an edge with loadACC=1, muxACC=00 and opALU in {00,01}; otherwise it SHALL hold.
REQ-008 zflag SHALL be registered and equal (ACC==0) in every cycle after any edge.
REQ-009 The multiplier SHALL be sequential shift-add, unsigned, MN x MN -> DW bits. It SHALL have two states:
- IDLE: when mult_start=1 at an edge, it captures MDR[MN-1:0] and ACC[MN-1:0], clears the partial product, loads count = MN, and moves to RUN.
- RUN: it performs one add/shift per edge; when count reaches 0 it writes the product register and returns to IDLE.
REQ-010 mult_busy SHALL be 1 exactly in RUN. If the start edge is k, mult_busy SHALL be high in cycles k+1..k+MN, and mult_done SHALL be high only in cycle k+MN+1.
REQ-011 The product register SHALL update only at completion; it SHALL be readable through muxACC=10 at any time and keep its last value.
REQ-012 mult_start SHALL be ignored while busy. mult_start asserted in the mult_done cycle SHALL start a new operation at that edge.
REQ-013 Changes to ACC or MDR during RUN SHALL NOT affect the product in flight.
REQ-014 loadACC with muxACC=10 during RUN SHALL load the previous product and SHALL NOT stall or abort the multiply.
REQ-015 Operand bits above MN-1 SHALL be ignored by the multiplier.

Reset
REQ-016 On an edge with rst=1, the following SHALL hold on the next cycle, overriding all other inputs:
- PC, MAR, IR, MDR, ACC and product register = 0.
- zflag = 1; cflag = 0.
- Multiplier in IDLE; mult_busy = 0; mult_done = 0.
REQ-017 rst during RUN SHALL abort the multiply: no mult_done pulse and no product write. mult_start held during rst SHALL be ignored.

Verification (DW=16, AW=8)
REQ-018 Reset, then loadPC=1, muxPC=0 for 256 cycles -> PC counts 0..255 and returns to 0; zflag=1 and cflag=0 throughout.
REQ-019 ACC=0xFFFF, MDR=0x0001, ADD -> ACC=0x0000, cflag=1, zflag=1. Then MDR=0x0002, SUB -> ACC=0xFFFE, cflag=1, zflag=0.
REQ-020 MDR=0x00FF, ACC=0x00FF, mult_start pulse at edge k -> mult_busy high in cycles k+1..k+8, mult_done only in cycle k+9. A later loadACC with muxACC=10 gives ACC=0xFE01.
REQ-021 During a multiply, change ACC and MDR every cycle and pulse mult_start again -> the product reflects the original operands and only one mult_done occurs. Then assert mult_start in the done cycle -> a second operation completes 9 cycles later.
REQ-022 Assert rst in cycle k+4 of a multiply -> no mult_done, product register=0, all outputs at reset values. A fresh multiply of 0x0003 x 0x0005 afterwards yields 0x000F.
REQ-023 MemQ=0x2A07, loadMDR then loadIR -> opcode=0x07. Then loadMAR with muxMAR=1 -> MemAddr=0x2A. loadPC with muxPC=1 -> PC=0x2A.

Source files
------------

// File: rtl/acc_datapath_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acc_datapath_gen : accumulator datapath (PC/MAR/IR/MDR/ACC, ALU, flags)
//                    with a sequential shift-add MN x MN multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------
module acc_datapath_gen #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int OPW = DW - AW,
  parameter int MN  = DW / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           loadPC,
  input  logic           muxPC,
  input  logic           loadMAR,
  input  logic           muxMAR,
  input  logic           loadIR,
  input  logic           loadMDR,
  input  logic           loadACC,
  input  logic [1:0]     muxACC,
  input  logic [1:0]     opALU,
  input  logic           mult_start,
  output logic           mult_busy,
  output logic           mult_done,
  output logic           zflag,
  output logic           cflag,
  output logic [OPW-1:0] opcode,
  output logic [AW-1:0]  MemAddr,
  output logic [DW-1:0]  MemD,
  input  logic [DW-1:0]  MemQ
);

  localparam int CW = $clog2(MN + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [AW-1:0] pc_q, mar_q;
  logic [DW-1:0] ir_q, mdr_q, acc_q, prod_q;
  logic          zflag_q, cflag_q, done_q;
  state_t        state_q;
  logic [DW-1:0] mcand_q, part_q;
  logic [MN-1:0] mplier_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] op_addr, pc_inc;
  logic [DW:0]   sum, diff;
  logic [DW-1:0] alu_res, acc_d, part_d;
  logic          alu_c, cflag_d;

  always_comb begin
    op_addr = ir_q[DW-1:OPW];
    pc_inc  = pc_q + AW'(1);
    sum     = {1'b0, acc_q} + {1'b0, mdr_q};
    diff    = {1'b0, acc_q} - {1'b0, mdr_q};
    alu_res = sum[DW-1:0];
    alu_c   = sum[DW];
    case (opALU)
      2'b00: begin alu_res = sum[DW-1:0];    alu_c = sum[DW];  end
      2'b01: begin alu_res = diff[DW-1:0];   alu_c = diff[DW]; end
      2'b10: begin alu_res = acc_q & mdr_q;  alu_c = 1'b0;     end
      default: begin alu_res = acc_q | mdr_q; alu_c = 1'b0;    end
    endcase

    acc_d   = acc_q;
    cflag_d = cflag_q;
    if (loadACC) begin
      case (muxACC)
        2'b00: begin
          acc_d = alu_res;
          // Only ADD/SUB produce a carry worth remembering.
          if (!opALU[1]) cflag_d = alu_c;
        end
        2'b01:   acc_d = mdr_q;
        2'b10:   acc_d = prod_q;
        default: acc_d = '0;
      endcase
    end

    part_d = part_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      zflag_q  <= 1'b1;
      cflag_q  <= 1'b0;
      done_q   <= 1'b0;
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (loadPC)  pc_q  <= muxPC  ? op_addr : pc_inc;
      if (loadMAR) mar_q <= muxMAR ? op_addr : pc_q;
      if (loadIR)  ir_q  <= mdr_q;
      if (loadMDR) mdr_q <= MemQ;
      acc_q   <= acc_d;
      cflag_q <= cflag_d;
      zflag_q <= (acc_d == '0);
      done_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (mult_start) begin
            mcand_q  <= {{(DW-MN){1'b0}}, acc_q[MN-1:0]};
            mplier_q <= mdr_q[MN-1:0];
            part_q   <= '0;
            cnt_q    <= CW'(MN);
            state_q  <= S_RUN;
          end
        end
        default: begin
          part_q   <= part_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            prod_q  <= part_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign mult_busy = (state_q == S_RUN);
  assign mult_done = done_q;
  assign zflag     = zflag_q;
  assign cflag     = cflag_q;
  assign opcode    = ir_q[OPW-1:0];
  assign MemAddr   = mar_q;
  assign MemD      = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_datapath_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_acc_datapath_gen : directed + random bench with a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_acc_datapath_gen;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MN = 8;

  logic          clk = 1'b0;
  logic          rst, loadPC, muxPC, loadMAR, muxMAR, loadIR, loadMDR, loadACC;
  logic [1:0]    muxACC, opALU;
  logic          mult_start, mult_busy, mult_done, zflag, cflag;
  logic [7:0]    opcode;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemD, MemQ;

  acc_datapath_gen #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .loadPC(loadPC), .muxPC(muxPC),
    .loadMAR(loadMAR), .muxMAR(muxMAR), .loadIR(loadIR), .loadMDR(loadMDR),
    .loadACC(loadACC), .muxACC(muxACC), .opALU(opALU),
    .mult_start(mult_start), .mult_busy(mult_busy), .mult_done(mult_done),
    .zflag(zflag), .cflag(cflag), .opcode(opcode), .MemAddr(MemAddr),
    .MemD(MemD), .MemQ(MemQ)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Architectural model: plain register values plus an abstract multiply
  // job (operands captured, product known up front, edges remaining).
  int           m_pc, m_mar, m_ir, m_mdr, m_acc, m_prod, m_res, m_left;
  bit           m_z, m_c, m_busy, m_done, model_ok;
  int           acc_nx, s;
  bit           c_nx;

  always_comb begin
    acc_nx = m_acc;
    c_nx   = m_c;
    s      = 0;
    if (loadACC) begin
      case (muxACC)
        2'd0: begin
          case (opALU)
            2'd0: begin s = m_acc + m_mdr; acc_nx = s % 65536; c_nx = (s > 65535); end
            2'd1: begin s = m_acc - m_mdr; acc_nx = (s + 65536) % 65536; c_nx = (m_mdr > m_acc); end
            2'd2: acc_nx = m_acc & m_mdr;
            default: acc_nx = m_acc | m_mdr;
          endcase
        end
        2'd1: acc_nx = m_mdr;
        2'd2: acc_nx = m_prod;
        default: acc_nx = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 0; m_mar <= 0; m_ir <= 0; m_mdr <= 0; m_acc <= 0; m_prod <= 0;
      m_z <= 1; m_c <= 0; m_busy <= 0; m_done <= 0; m_left <= 0; m_res <= 0;
    end else begin
      if (loadPC)  m_pc  <= muxPC ? (m_ir / 256) : (m_pc + 1) % 256;
      if (loadMAR) m_mar <= muxMAR ? (m_ir / 256) : m_pc;
      if (loadIR)  m_ir  <= m_mdr;
      if (loadMDR) m_mdr <= int'(MemQ);
      m_acc  <= acc_nx;
      m_c    <= c_nx;
      m_z    <= (acc_nx == 0);
      m_done <= 0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 0; m_prod <= m_res; m_done <= 1;
        end else m_left <= m_left - 1;
      end else if (mult_start) begin
        m_busy <= 1; m_left <= MN;
        m_res  <= (m_mdr % 256) * (m_acc % 256);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy",    mult_busy, m_busy);
      chk("done",    mult_done, m_done);
      chk("zflag",   zflag,     m_z);
      chk("cflag",   cflag,     m_c);
      chk("opcode",  opcode,    m_ir % 256);
      chk("MemAddr", MemAddr,   m_mar);
      chk("MemD",    MemD,      m_acc);
    end
  end

  task automatic idle();
    rst = 0; loadPC = 0; muxPC = 0; loadMAR = 0; muxMAR = 0; loadIR = 0;
    loadMDR = 0; loadACC = 0; muxACC = 0; opALU = 0; mult_start = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ld_mdr(input logic [DW-1:0] v);
    idle(); MemQ = v; loadMDR = 1; step();
  endtask

  task automatic ld_acc(input logic [1:0] mx, input logic [1:0] op);
    idle(); loadACC = 1; muxACC = mx; opALU = op; step();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_D"}, MemD, 16'h0000);
    chk({nm, "_z"}, zflag, 1'b1);
    chk({nm, "_c"}, cflag, 1'b0);
    chk({nm, "_busy"}, mult_busy, 1'b0);
    chk({nm, "_done"}, mult_done, 1'b0);
    chk({nm, "_addr"}, MemAddr, 8'h00);
    chk({nm, "_op"}, opcode, 8'h00);
  endtask

  initial begin
    model_ok = 0;
    MemQ = '0;
    idle();
    rst = 1;
    @(negedge clk);
    step();
    model_ok = 1;
    chk_reset_vals("reset");

    // PC walk observed through MAR (MAR lags PC by one edge).
    idle(); loadPC = 1; loadMAR = 1;
    for (int n = 1; n <= 257; n++) begin
      step();
      chk("pc_walk", MemAddr, (n - 1) % 256);
      chk("pc_walk_z", zflag, 1'b1);
      chk("pc_walk_c", cflag, 1'b0);
    end

    // ADD overflow to zero, then SUB with borrow.
    ld_mdr(16'hFFFF); ld_acc(2'b01, 2'b00);
    ld_mdr(16'h0001); ld_acc(2'b00, 2'b00);
    chk("add_acc", MemD, 16'h0000); chk("add_c", cflag, 1'b1); chk("add_z", zflag, 1'b1);
    ld_mdr(16'h0002); ld_acc(2'b00, 2'b01);
    chk("sub_acc", MemD, 16'hFFFE); chk("sub_c", cflag, 1'b1); chk("sub_z", zflag, 1'b0);
    ld_acc(2'b00, 2'b10);
    chk("and_c_hold", cflag, 1'b1);

    // 0xFF x 0xFF with exact busy/done timing.
    ld_mdr(16'h00FF); ld_acc(2'b01, 2'b00);
    idle(); mult_start = 1; step(); idle();
    chk("m1_busy0", mult_busy, 1'b1);
    for (int i = 1; i < MN; i++) begin
      step(); chk("m1_busy", mult_busy, 1'b1); chk("m1_nodone", mult_done, 1'b0);
    end
    step(); chk("m1_done", mult_done, 1'b1); chk("m1_idle", mult_busy, 1'b0);
    step(); chk("m1_done_off", mult_done, 1'b0);
    ld_acc(2'b10, 2'b00);
    chk("m1_prod", MemD, 16'hFE01);

    // Operands disturbed during RUN; restart in the done cycle.
    ld_mdr(16'h1234); ld_acc(2'b01, 2'b00); ld_mdr(16'h0007);
    idle(); mult_start = 1; step();
    for (int i = 1; i <= MN; i++) begin
      idle(); MemQ = DW'($urandom); loadMDR = 1; loadACC = 1; muxACC = 2'b01; mult_start = 1;
      step();
      if (i < MN) chk("m2_nodone", mult_done, 1'b0);
      else        chk("m2_done", mult_done, 1'b1);
    end
    idle(); mult_start = 1; loadACC = 1; muxACC = 2'b10; step(); idle();
    chk("m2_prod", MemD, 16'h016C); chk("m3_busy", mult_busy, 1'b1);
    for (int i = 1; i < MN; i++) begin
      step(); chk("m3_nodone", mult_done, 1'b0);
    end
    step(); chk("m3_done", mult_done, 1'b1);

    // Reset mid-multiply aborts it; a fresh 3 x 5 follows.
    idle(); mult_start = 1; step(); idle();
    for (int i = 0; i < 3; i++) step();
    rst = 1; mult_start = 1; step(); idle();
    chk_reset_vals("abort");
    for (int i = 0; i < 10; i++) begin
      step(); chk("abort_nodone", mult_done, 1'b0);
    end
    ld_mdr(16'h0003); ld_acc(2'b01, 2'b00); ld_acc(2'b10, 2'b00);
    chk("abort_prod0", MemD, 16'h0000);
    ld_acc(2'b01, 2'b00); ld_mdr(16'h0005);
    idle(); mult_start = 1; step(); idle();
    for (int i = 0; i < MN; i++) step();
    chk("m4_done", mult_done, 1'b1);
    ld_acc(2'b10, 2'b00);
    chk("m4_prod", MemD, 16'h000F);

    // Instruction fetch path: opcode, operand address to MAR and PC.
    ld_mdr(16'h2A07);
    idle(); loadIR = 1; step();
    chk("ir_opcode", opcode, 8'h07);
    idle(); loadMAR = 1; muxMAR = 1; step();
    chk("mar_opaddr", MemAddr, 8'h2A);
    idle(); loadPC = 1; muxPC = 1; step();
    idle(); loadMAR = 1; muxMAR = 0; step();
    chk("pc_jump", MemAddr, 8'h2A);

    // Random traffic checked by the model on every cycle.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst        = ($urandom_range(0, 99) == 0);
      loadPC     = 1'($urandom);
      muxPC      = 1'($urandom);
      loadMAR    = 1'($urandom);
      muxMAR     = 1'($urandom);
      loadIR     = ($urandom_range(0, 3) == 0);
      loadMDR    = 1'($urandom);
      loadACC    = 1'($urandom);
      muxACC     = 2'($urandom);
      opALU      = 2'($urandom);
      mult_start = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 7);
      MemQ = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : DW'($urandom);
      step();
    end

    idle(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
